// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol-class enum, fixed code tables and a byte popcount helper.
package tmds_pkg;

   typedef enum logic [1:0] {
      MODE_VIDEO  = 2'd0,
      MODE_CTRL   = 2'd1,
      MODE_TERC4  = 2'd2,
      MODE_VGUARD = 2'd3
   } tmds_mode_t;

   localparam logic [9:0] CTRL_TOKEN [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [9:0] GUARD_VID_02 = 10'b1011001100;
   localparam logic [9:0] GUARD_VID_1  = 10'b0100110011;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_qm.sv
// Transition-minimisation stage: 8-bit byte to 9-bit q_m (XOR or XNOR chain, bit 8 flags XOR).
module tmds_qm
   import tmds_pkg::*;
(
   input  logic [7:0] data,
   output logic [8:0] qm
);

   logic [3:0] n1;
   logic       use_xnor;
   logic [7:0] chain;

   always_comb begin
      n1       = popcount8(data);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
      chain    = '0;
      chain[0] = data[0];
      for (int unsigned i = 1; i < 8; i++) begin
         chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
      end
      qm = {~use_xnor, chain};
   end

endmodule

// File: rtl/tmds_encoder_dc.sv
// TMDS lane encoder: 2-stage pipeline producing video (DC-balanced), control, TERC4 and guard symbols.
module tmds_encoder_dc
   import tmds_pkg::*;
#(
   parameter int unsigned CHANNEL = 0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [1:0] mode_in,
   input  logic [7:0] data_in,
   input  logic [1:0] control_in,
   input  logic [3:0] terc4_in,
   output logic [9:0] tmds_out,
   output logic [4:0] tally_out
);

   if (CHANNEL > 2) begin : g_bad_channel
      $error("tmds_encoder_dc: CHANNEL must be 0, 1 or 2");
   end

   tmds_mode_t        mode_a;
   logic [1:0]        ctrl_a;
   logic [3:0]        terc4_a;
   logic [8:0]        qm_a;
   logic [3:0]        n1_a;
   logic [8:0]        qm_c;

   logic signed [4:0] tally;
   logic signed [4:0] tally_nxt;
   logic signed [4:0] diff;
   logic signed [4:0] q8x2;
   logic signed [4:0] nq8x2;
   logic [9:0]        sym_nxt;
   logic [9:0]        guard_sym;

   tmds_qm u_qm (
      .data (data_in),
      .qm   (qm_c)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mode_a  <= MODE_CTRL;
         ctrl_a  <= '0;
         terc4_a <= '0;
         qm_a    <= '0;
         n1_a    <= '0;
      end else begin
         mode_a  <= tmds_mode_t'(mode_in);
         ctrl_a  <= control_in;
         terc4_a <= terc4_in;
         qm_a    <= qm_c;
         n1_a    <= popcount8(qm_c[7:0]);
      end
   end

   assign guard_sym = (CHANNEL == 1) ? GUARD_VID_1 : GUARD_VID_02;

   always_comb begin
      // N1-N0 == 2*N1-8; 5-bit wrap keeps the N1==8 case correct (+8)
      diff      = $signed({n1_a, 1'b0}) - 5'sd8;
      q8x2      = $signed({3'b000, qm_a[8], 1'b0});
      nq8x2     = $signed({3'b000, ~qm_a[8], 1'b0});
      sym_nxt   = CTRL_TOKEN[ctrl_a];
      tally_nxt = '0;
      case (mode_a)
         MODE_VIDEO: begin
            if ((tally == 5'sd0) || (n1_a == 4'd4)) begin
               sym_nxt   = {~qm_a[8], qm_a[8], qm_a[8] ? qm_a[7:0] : ~qm_a[7:0]};
               tally_nxt = qm_a[8] ? (tally + diff) : (tally - diff);
            end else if (((tally > 5'sd0) && (diff > 5'sd0)) ||
                         ((tally < 5'sd0) && (diff < 5'sd0))) begin
               sym_nxt   = {1'b1, qm_a[8], ~qm_a[7:0]};
               tally_nxt = tally + q8x2 - diff;
            end else begin
               sym_nxt   = {1'b0, qm_a[8], qm_a[7:0]};
               tally_nxt = tally + diff - nq8x2;
            end
         end
         MODE_CTRL:   sym_nxt = CTRL_TOKEN[ctrl_a];
         MODE_TERC4:  sym_nxt = TERC4_TABLE[terc4_a];
         MODE_VGUARD: sym_nxt = guard_sym;
         default:     sym_nxt = CTRL_TOKEN[ctrl_a];
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tmds_out <= CTRL_TOKEN[0];
         tally    <= '0;
      end else begin
         tmds_out <= sym_nxt;
         tally    <= tally_nxt;
      end
   end

   assign tally_out = tally;

endmodule

// File: tb/tb_tmds_encoder_dc.sv
// Scoreboard bench for tmds_encoder_dc: two lanes (CHANNEL 1 and 2) fed identical stimulus.
module tb_tmds_encoder_dc;

   localparam logic [1:0] M_VIDEO = 2'd0;
   localparam logic [1:0] M_CTRL  = 2'd1;
   localparam logic [1:0] M_TERC4 = 2'd2;
   localparam logic [1:0] M_VG    = 2'd3;

   localparam logic [9:0] G02 = 10'b1011001100;
   localparam logic [9:0] G1  = 10'b0100110011;

   logic [9:0] ctrl_tab [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };
   logic [9:0] terc_tab [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   typedef struct {
      bit         chk;
      bit         vid;
      logic [7:0] d;
      logic [9:0] s1;
      logic [9:0] s2;
      int         tal;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic [3:0] terc4;
   logic [9:0] sym1, sym2;
   logic [4:0] tal1, tal2;

   exp_t q[$];
   int   model_tal;
   int   prev_obs;
   int   checks = 0;
   int   errors = 0;

   tmds_encoder_dc #(.CHANNEL(1)) dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .mode_in    (mode),
      .data_in    (data),
      .control_in (ctrl),
      .terc4_in   (terc4),
      .tmds_out   (sym1),
      .tally_out  (tal1)
   );

   tmds_encoder_dc #(.CHANNEL(2)) dut2 (
      .clk_in     (clk),
      .rst_in     (rst),
      .mode_in    (mode),
      .data_in    (data),
      .control_in (ctrl),
      .terc4_in   (terc4),
      .tmds_out   (sym2),
      .tally_out  (tal2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] qq;
      logic [7:0] d;
      qq   = s[9] ? ~s[7:0] : s[7:0];
      d    = '0;
      d[0] = qq[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = s[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
      end
      return d;
   endfunction

   task automatic model(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                        input logic [3:0] t, output logic [9:0] s1, output logic [9:0] s2);
      int         ones;
      int         n1;
      int         df;
      bit         xn;
      bit         q8;
      logic [7:0] qv;
      s1 = ctrl_tab[c];
      case (m)
         M_VIDEO: begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
            q8    = !xn;
            qv[0] = d[0];
            for (int i = 1; i < 8; i++) qv[i] = xn ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(qv[i]);
            df = n1 - (8 - n1);
            if (model_tal == 0 || df == 0) begin
               s1 = {~q8, q8, q8 ? qv : ~qv};
               model_tal += q8 ? df : -df;
            end else if ((model_tal > 0 && df > 0) || (model_tal < 0 && df < 0)) begin
               s1 = {1'b1, q8, ~qv};
               model_tal += 2 * int'(q8) - df;
            end else begin
               s1 = {1'b0, q8, qv};
               model_tal += df - (q8 ? 0 : 2);
            end
         end
         M_CTRL:  begin s1 = ctrl_tab[c]; model_tal = 0; end
         M_TERC4: begin s1 = terc_tab[t]; model_tal = 0; end
         default: begin s1 = G1;          model_tal = 0; end
      endcase
      s2 = (m == M_VG) ? G02 : s1;
   endtask

   task automatic sample();
      exp_t              e;
      logic signed [31:0] t1, t2;
      int                ones;
      t1 = {{27{tal1[4]}}, tal1};
      t2 = {{27{tal2[4]}}, tal2};
      if (q.size() >= 2) begin
         e = q.pop_front();
         if (e.chk) begin
            check("sym_ch1", {22'b0, sym1}, {22'b0, e.s1});
            check("sym_ch2", {22'b0, sym2}, {22'b0, e.s2});
            check("tally_ch1", t1, e.tal);
            check("tally_ch2", t2, e.tal);
            if (e.vid) begin
               ones = 0;
               for (int i = 0; i < 10; i++) ones += int'(sym1[i]);
               check("decode", {24'b0, decode(sym1)}, {24'b0, e.d});
               check("tally_bound", {31'b0, (t1 >= -10 && t1 <= 10)}, 32'd1);
               check("disparity", t1 - prev_obs, 2 * ones - 10);
            end
         end
      end
      prev_obs = t1;
   endtask

   task automatic drive(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                        input logic [3:0] t);
      exp_t e;
      mode  = m;
      data  = d;
      ctrl  = c;
      terc4 = t;
      model(m, d, c, t, e.s1, e.s2);
      e.chk = 1'b1;
      e.vid = (m == M_VIDEO);
      e.d   = d;
      e.tal = model_tal;
      q.push_back(e);
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic do_reset();
      exp_t e;
      rst  = 1'b1;
      mode = M_VIDEO;
      data = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_sym_ch1", {22'b0, sym1}, {22'b0, ctrl_tab[0]});
      check("rst_sym_ch2", {22'b0, sym2}, {22'b0, ctrl_tab[0]});
      check("rst_tally", {27'b0, tal1}, 32'd0);
      q.delete();
      model_tal = 0;
      prev_obs  = 0;
      rst       = 1'b0;
      // stage A was loaded with CTRL 00 by reset; it leaves stage B on the next edge
      e.chk = 1'b1;
      e.vid = 1'b0;
      e.d   = '0;
      e.s1  = ctrl_tab[0];
      e.s2  = ctrl_tab[0];
      e.tal = 0;
      q.push_back(e);
   endtask

   initial begin
      rst       = 1'b1;
      mode      = M_CTRL;
      data      = '0;
      ctrl      = '0;
      terc4     = '0;
      model_tal = 0;
      prev_obs  = 0;

      do_reset();
      repeat (3) drive(M_VIDEO, 8'h00, 2'd0, 4'd0);

      do_reset();
      drive(M_VIDEO, 8'hFF, 2'd0, 4'd0);

      drive(M_VIDEO, 8'h00, 2'd0, 4'd0);
      drive(M_VIDEO, 8'h00, 2'd0, 4'd0);
      drive(M_VIDEO, 8'h00, 2'd0, 4'd0);
      drive(M_CTRL,  8'h00, 2'd1, 4'd0);
      drive(M_VIDEO, 8'h00, 2'd0, 4'd0);

      for (int t = 0; t < 16; t++) drive(M_TERC4, 8'h00, 2'd0, 4'(t));
      drive(M_VG, 8'h00, 2'd0, 4'd0);
      drive(M_VG, 8'h00, 2'd0, 4'd0);
      for (int c = 0; c < 4; c++) drive(M_CTRL, 8'h00, 2'(c), 4'd0);

      repeat (10000) drive(M_VIDEO, 8'($urandom), 2'd0, 4'd0);

      repeat (200) drive(2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom), 4'($urandom));

      repeat (3) drive(M_VIDEO, 8'($urandom), 2'd0, 4'd0);
      do_reset();
      repeat (4) drive(M_VIDEO, 8'($urandom), 2'd0, 4'd0);

      repeat (2) drive(M_CTRL, 8'h00, 2'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
